// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RISC-V control unit.
// Holds the FSM state enum, the supported opcodes, the datapath mux-select
// encodings (ResultSrc, ALUSrcA, ALUSrcB) and the ALUOp / ALUControl codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // Supported opcodes
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ALUOp (internal, FSM to ALU decoder)
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: purely combinational mapping from the FSM's ALUOp plus the
// instruction fields to the ALU operation code.
// Ports:
//   alu_op      in  2  00 add, 01 sub, 10 decode funct3
//   funct3      in  3  instruction funct3
//   funct7_5    in  1  instruction funct7[5]
//   op_5        in  1  instruction opcode[5] (1 = R-type, 0 = I-type ALU)
//   alu_control out 3  ALU operation
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type has a sub; addi with imm[10]=1 must still add.
          3'b000:  alu_control = (funct7_5 & op_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing fetch/decode/execute/memory/
// writeback for the multicycle RISC-V core, driving every datapath enable
// and mux select.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   opcode/funct3/funct7 instruction register fields (only funct7[5] used)
//   zero                ALU zero flag, qualifies the beq PC write
//   mem_ready           unified memory access complete
//   IRwrite, PCwrite, AdrSrc, MemWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl        datapath mux/ALU codes
//   illegal_instr       one-cycle pulse in DECODE for an unsupported opcode
//
// Memory handshake: the control unit holds its request (address select and,
// for stores, MemWrite) steady in FETCH, MEMREAD and MEMWRITE; an access
// completes in the cycle mem_ready is high, and the FSM leaves that state on
// the following edge. mem_ready is ignored in every other state.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IRwrite,
  output logic       PCwrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       illegal_instr
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    IRwrite       = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed and written alongside the IR load.
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRwrite   = mem_ready;
        pc_update = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm: branch/jump target, latched into ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC <- target held in ALUOut; ALU forms OldPC + 4 for rd.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign PCwrite = pc_update | (branch & zero);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .op_5        (opcode[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed bench for multicycle_control. Inputs change
// 1 ns after the rising edge; all outputs are packed into one vector and
// checked on the falling edge against hand-computed per-state values.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       IRwrite, PCwrite, AdrSrc, MemWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl;
  logic [14:0] outs;

  int n_cmp  = 0;
  int n_fail = 0;

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .IRwrite       (IRwrite),
    .PCwrite       (PCwrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUControl    (ALUControl),
    .illegal_instr (illegal_instr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs = {IRwrite, PCwrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, illegal_instr};

  // Expected-vector builder: ir, pc, adr, mw, rw, result, srca, srcb, aluctl, ill
  function automatic logic [14:0] pk(input logic ir, input logic pc,
      input logic adr, input logic mw, input logic rw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ac,
      input logic ill);
    return {ir, pc, adr, mw, rw, rs, sa, sb, ac, ill};
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs,
                     input logic [14:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Check the current state's outputs mid-cycle, then advance one cycle.
  task automatic cyc(input string tag, input logic [14:0] exp);
    @(negedge clk);
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  logic [14:0] f_rdy, f_wait, dec, dec_ill, madr, mrd, mwb, mwr, awb, jal;

  initial begin
    f_rdy   = pk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    f_wait  = pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    dec     = pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
    dec_ill = pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 1);
    madr    = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    mrd     = pk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    mwb     = pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);
    mwr     = pk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    awb     = pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    jal     = pk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);

    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = 7'b0000011; funct3 = 3'b000; funct7 = 7'b0000000;

    // Reset held
    cyc("reset_hold", f_wait);
    cyc("reset_hold2", f_wait);
    reset = 1'b0;
    // Released with no memory response: stays in FETCH
    cyc("fetch_wait0", f_wait);
    cyc("fetch_wait1", f_wait);

    // lw, zero-wait: FETCH DECODE MEMADR MEMREAD MEMWB
    mem_ready = 1'b1;
    cyc("lw_fetch", f_rdy);
    cyc("lw_decode", dec);
    cyc("lw_memadr", madr);
    cyc("lw_memread", mrd);
    cyc("lw_memwb", mwb);

    // sw with 3 wait cycles in MEMWRITE
    opcode = 7'b0100011;
    cyc("sw_fetch", f_rdy);
    cyc("sw_decode", dec);
    mem_ready = 1'b0;   // ignored in MEMADR
    cyc("sw_memadr", madr);
    cyc("sw_memwrite_w0", mwr);
    cyc("sw_memwrite_w1", mwr);
    cyc("sw_memwrite_w2", mwr);
    mem_ready = 1'b1;
    cyc("sw_memwrite_done", mwr);

    // R-type sub
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
    cyc("rsub_fetch", f_rdy);
    cyc("rsub_decode", dec);
    cyc("rsub_exec", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
    cyc("rsub_aluwb", awb);

    // R-type and
    funct3 = 3'b111; funct7 = 7'b0000000;
    cyc("rand_fetch", f_rdy);
    cyc("rand_decode", dec);
    cyc("rand_exec", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 0));
    cyc("rand_aluwb", awb);

    // R-type or
    funct3 = 3'b110;
    cyc("ror_fetch", f_rdy);
    cyc("ror_decode", dec);
    cyc("ror_exec", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 0));
    cyc("ror_aluwb", awb);

    // addi with funct7[5]=1: opcode[5]=0 so still add
    opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0100000;
    cyc("addi_fetch", f_rdy);
    cyc("addi_decode", dec);
    cyc("addi_exec", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
    cyc("addi_aluwb", awb);

    // slti
    funct3 = 3'b010; funct7 = 7'b0000000;
    cyc("slti_fetch", f_rdy);
    cyc("slti_decode", dec);
    cyc("slti_exec", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 0));
    cyc("slti_aluwb", awb);

    // I-ALU with unsupported funct3 (xori) falls back to add
    funct3 = 3'b100;
    cyc("xori_fetch", f_rdy);
    cyc("xori_decode", dec);
    cyc("xori_exec", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
    cyc("xori_aluwb", awb);

    // beq taken (zero is high throughout; only BEQ may use it)
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    cyc("beq1_fetch", f_rdy);
    cyc("beq1_decode", dec);
    cyc("beq1_beq", pk(0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
    // beq not taken
    zero = 1'b0;
    cyc("beq0_fetch", f_rdy);
    cyc("beq0_decode", dec);
    cyc("beq0_beq", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0));

    // jal
    opcode = 7'b1101111;
    cyc("jal_fetch", f_rdy);
    cyc("jal_decode", dec);
    cyc("jal_jal", jal);
    cyc("jal_aluwb", awb);

    // illegal opcode: 2 cycles
    opcode = 7'b1111111;
    cyc("ill_fetch", f_rdy);
    cyc("ill_decode", dec_ill);

    // FETCH wait then lw, reset asserted mid-MEMREAD
    opcode = 7'b0000011; mem_ready = 1'b0;
    cyc("rst_fetch_wait", f_wait);
    mem_ready = 1'b1;
    cyc("rst_fetch", f_rdy);
    cyc("rst_decode", dec);
    mem_ready = 1'b0;
    cyc("rst_memadr", madr);
    #2;
    chk("rst_memread", outs, mrd);
    reset = 1'b1;
    #1;
    chk("rst_async", outs, f_wait);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1;   // would complete the read if the lw had survived
    cyc("rst_restart_fetch", f_rdy);
    cyc("rst_restart_decode", dec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed running required finished");
    $fatal(1, "time limit");
  end

endmodule
